// File: rtl/fft_pkg.sv
// Shared FFT address-path constants and the shift-amount reduction helper.
package fft_pkg;

  localparam int unsigned FFT_IDX_W   = 5;
  localparam int unsigned FFT_SHIFT_W = 3;

  // Reduce a rotate amount into 0..w-1. Constant w folds to a small lookup.
  function automatic int unsigned mod_width(input int unsigned s,
                                            input int unsigned w = FFT_IDX_W);
    return s % w;
  endfunction

endpackage

// File: rtl/rotr_comb.sv
// Combinational WIDTH-bit barrel rotate-right, one mux leg per amount.
module rotr_comb #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned SW    = 3
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic [SW-1:0]    k_i,
  output logic [WIDTH-1:0] q_o
);

  // NOTE: q_o gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    q_o = d_i;
    for (int i = 1; i < int'(WIDTH); i++) begin
      if (k_i == SW'(i)) q_o = (d_i >> i) | (d_i << (int'(WIDTH) - i));
    end
  end

endmodule

// File: rtl/rotate_right_by_s_stream.sv
// Two-stage valid/ready pipeline that rotates an FFT index right by s mod WIDTH,
// undoing the rotate-left applied on the address path.
module rotate_right_by_s_stream
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = FFT_IDX_W,
  parameter int unsigned SW    = FFT_SHIFT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  input  logic [SW-1:0]    in_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       occupancy
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_d_q, s1_d_d;
  logic [SW-1:0]    s1_s_q, s1_s_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_q_q, s2_q_d;
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] rot;
  logic             advance1, advance2;

  rotr_comb #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_rotr (
    .d_i (s1_d_q),
    .k_i (s1_s_q),
    .q_o (rot)
  );

  // Ready ripples back from the consumer; flush blocks new input for its cycle.
  assign advance2 = !s2_valid_q || out_ready;
  assign advance1 = !s1_valid_q || advance2;
  assign in_ready = advance1 && !flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d_d     = s1_d_q;
    s1_s_d     = s1_s_q;
    s2_valid_d = s2_valid_q;
    s2_q_d     = s2_q_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (advance2) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) s2_q_d = rot;
      end
      if (advance1) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_d_d = in_d;
          s1_s_d = SW'(mod_width(32'(in_s), WIDTH));
        end
      end
    end
    occ_d = {1'b0, s1_valid_d} + {1'b0, s2_valid_d};
  end

  // NOTE: data registers are reset along with the valids so out_q reads 0 in reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_valid_q <= 1'b0;
      s1_d_q     <= '0;
      s1_s_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_q_q     <= '0;
      occ_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_d_q     <= s1_d_d;
      s1_s_q     <= s1_s_d;
      s2_valid_q <= s2_valid_d;
      s2_q_q     <= s2_q_d;
      occ_q      <= occ_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_q     = s2_q_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_rotate_right_by_s_stream.sv
// Bench for rotate_right_by_s_stream: queue-based in-flight model checked every
// cycle, plus directed vectors with literal expectations.
module tb_rotate_right_by_s_stream;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_d = '0;
  logic [2:0] in_s = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_q;
  logic [1:0] occupancy;

  rotate_right_by_s_stream dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d      (in_d),
    .in_s      (in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rotation one bit at a time, k times.
  function automatic logic [4:0] model_rotr(input logic [4:0] d, input int k);
    for (int i = 0; i < k; i++) d = {d[0], d[4:1]};
    return d;
  endfunction

  function automatic logic [4:0] model_rotl(input logic [4:0] d, input int k);
    for (int i = 0; i < k; i++) d = {d[3:0], d[4]};
    return d;
  endfunction

  // Beats accepted but not yet delivered, oldest first; age = edges survived since accept.
  typedef struct {
    logic [4:0] exp;
    logic [4:0] orig;
    int         age;
  } beat_t;

  beat_t      mq[$];
  logic [4:0] log_q[$];
  bit         rt_mode = 1'b0;
  logic [4:0] rt_orig = '0;

  int    sz;
  bit    ev, hs, eir;
  beat_t nb;

  always @(negedge clk) begin
    if (!clr) begin
      mq.delete();
    end else begin
      sz  = mq.size();
      ev  = (sz > 0) && (mq[0].age >= 1);
      eir = !flush && ((sz < 2) || out_ready);
      check("out_valid", int'(out_valid), int'(ev));
      check("occupancy", int'(occupancy), sz);
      check("in_ready", int'(in_ready), int'(eir));
      hs = ev && out_ready;
      if (hs) begin
        check("out_q", int'(out_q), int'(mq[0].exp));
        if (rt_mode) check("roundtrip", int'(out_q), int'(mq[0].orig));
        if (!flush) log_q.push_back(out_q);
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (hs) void'(mq.pop_front());
        foreach (mq[i]) mq[i].age++;
        if (in_valid && eir) begin
          nb.exp  = model_rotr(in_d, int'(in_s) % 5);
          nb.orig = rt_orig;
          nb.age  = 0;
          mq.push_back(nb);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rt_mode) begin
      #1;
      if (rt_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] d, input logic [2:0] s);
    in_valid = 1'b1;
    in_d     = d;
    in_s     = s;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (occupancy == 2'd0 && !out_valid) begin
        tick();
        return;
      end
      tick();
    end
    check("drain_timeout", 0, 1);
  endtask

  logic [4:0] exp2[5] = '{5'b10110, 5'b01011, 5'b10101, 5'b11010, 5'b01101};
  logic [4:0] exp3[3] = '{5'b00001, 5'b10000, 5'b01000};
  logic [4:0] exp4[4] = '{5'b11001, 5'b10011, 5'b10100, 5'b10000};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] d;
    int         k;

    check("pin_rotr3", int'(model_rotr(5'b10110, 3)), int'(5'b11010));
    check("pin_rotl2", int'(model_rotl(5'b00001, 2)), int'(5'b00100));

    repeat (2) tick();
    clr = 1'b1;
    tick();

    // Reset mid-stream with the pipeline full
    out_ready = 1'b0;
    send(5'b00011, 3'd1);
    send(5'b00111, 3'd2);
    #2;
    clr = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_occupancy", int'(occupancy), 0);
    check("rst_out_q", int'(out_q), 0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    check("rel_in_ready", int'(in_ready), 1);
    tick();

    // Rotations 0..4 streamed back to back
    out_ready = 1'b1;
    log_q.delete();
    for (int s = 0; s < 5; s++) send(5'b10110, 3'(s));
    wait_empty();
    check("t2_count", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) check("t2_value", int'(log_q[i]), int'(exp2[i]));

    // Latency: visible on the second edge after accept
    send(5'b10110, 3'd1);
    @(negedge clk);
    check("lat_early", int'(out_valid), 0);
    tick();
    @(negedge clk);
    check("lat_valid", int'(out_valid), 1);
    check("lat_data", int'(out_q), int'(5'b01011));
    tick();
    wait_empty();

    // Modulo reduction of the shift amount
    log_q.delete();
    send(5'b00001, 3'd5);
    send(5'b00001, 3'd6);
    send(5'b00001, 3'd7);
    wait_empty();
    check("t3_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) check("t3_value", int'(log_q[i]), int'(exp3[i]));

    // Backpressure with four beats
    log_q.delete();
    out_ready = 1'b0;
    send(5'b10011, 3'd1);
    send(5'b01110, 3'd2);
    in_valid = 1'b1;
    in_d     = 5'b00101;
    in_s     = 3'd3;
    repeat (3) begin
      @(negedge clk);
      check("bp_occupancy", int'(occupancy), 2);
      check("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    send(5'b00101, 3'd3);
    send(5'b01000, 3'd4);
    wait_empty();
    check("t4_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) check("t4_value", int'(log_q[i]), int'(exp4[i]));

    // Flush with both stages full and an input offered
    out_ready = 1'b0;
    send(5'b11000, 3'd1);
    send(5'b00110, 3'd2);
    in_valid = 1'b1;
    in_d     = 5'b10101;
    in_s     = 3'd0;
    flush    = 1'b1;
    @(negedge clk);
    check("fl_in_ready", int'(in_ready), 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("fl_occupancy", int'(occupancy), 0);
    check("fl_out_valid", int'(out_valid), 0);
    tick();
    log_q.delete();
    out_ready = 1'b1;
    repeat (5) tick();
    check("fl_no_output", log_q.size(), 0);

    // Round trip through rotate-left then this unit, random backpressure
    log_q.delete();
    rt_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      d       = 5'($urandom);
      k       = int'($urandom_range(0, 4));
      rt_orig = d;
      send(model_rotl(d, k), 3'(k));
    end
    wait_empty();
    rt_mode = 1'b0;
    tick();
    out_ready = 1'b1;
    check("rt_count", log_q.size(), 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
